mmcm_lock_supervisor: RTL and testbench

Supervisor FSM for the board MMCM clock generator. It runs on the free-running oscillator clock and drives the MMCM reset. It qualifies LOCKED with a synchronizer and a stability window, then releases the downstream system reset and clock-good flag. It also detects loss of lock, re-sequences the MMCM with bounded retries, and latches a fault when lock never arrives.

---
 rtl/mmcm_lock_supervisor.sv | 164 ++++++++++++++++
 tb/tb_mmcm_lock_supervisor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_lock_supervisor.sv
// MMCM lock supervisor: sequences the MMCM reset, qualifies LOCKED through a
// synchronizer and stability window, and gates the downstream reset and clock-good flag.
module mmcm_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 40000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic       osc_clk_i,
    input  logic       rst_i,
    input  logic       mmcm_locked_i,
    input  logic       force_reset_i,
    output logic       mmcm_rst_o,
    output logic       sys_reset_n_o,
    output logic       clock_good_o,
    output logic       fault_o,
    output logic [2:0] retry_cnt_o,
    output logic [7:0] lol_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET_PULSE = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_STABLE      = 3'd2,
        ST_RUN         = 3'd3,
        ST_FAULT       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_LAST      = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [31:0]      MAX_RETRIES_U = 32'(MAX_RETRIES);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   timer_r;
    logic [CNT_W-1:0]   timer_nxt_s;
    logic [2:0]         retry_cnt_r;
    logic [2:0]         retry_nxt_s;
    logic [7:0]         lol_cnt_r;
    logic [7:0]         lol_nxt_s;
    logic               sync_meta_r;
    logic               lock_sync_r;
    logic               mmcm_rst_r;
    logic               sys_reset_n_r;
    logic               clock_good_r;
    logic               fault_r;
    logic               last_retry_s;
    logic [2:0]         retry_inc_s;

    assign last_retry_s = (({29'd0, retry_cnt_r} + 32'd1) == MAX_RETRIES_U);
    assign retry_inc_s  = (retry_cnt_r == 3'd7) ? 3'd7 : (retry_cnt_r + 3'd1);

    // Two-flop synchronizer for the asynchronous LOCKED input.
    always_ff @(posedge osc_clk_i) begin
        if (rst_i) begin
            sync_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            sync_meta_r <= mmcm_locked_i;
            lock_sync_r <= sync_meta_r;
        end
    end

    // Next-state, timer and counter decisions; force_reset_i overrides all state logic.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        retry_nxt_s = retry_cnt_r;
        lol_nxt_s   = lol_cnt_r;
        if (force_reset_i) begin
            state_nxt_s = ST_RESET_PULSE;
            timer_nxt_s = '0;
            retry_nxt_s = 3'd0;
        end else begin
            case (state_r)
                ST_RESET_PULSE: begin
                    if (timer_r == RST_LAST) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        timer_nxt_s = '0;
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_nxt_s = ST_STABLE;
                        timer_nxt_s = '0;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_nxt_s = last_retry_s ? ST_FAULT : ST_RESET_PULSE;
                        retry_nxt_s = retry_inc_s;
                        timer_nxt_s = '0;
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    // A dropout restarts the timeout window without charging a retry.
                    if (!lock_sync_r) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        timer_nxt_s = '0;
                    end else if (timer_r == STABLE_LAST) begin
                        state_nxt_s = ST_RUN;
                        retry_nxt_s = 3'd0;
                        timer_nxt_s = '0;
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_nxt_s = ST_RESET_PULSE;
                        timer_nxt_s = '0;
                        lol_nxt_s   = (lol_cnt_r == 8'hFF) ? 8'hFF : (lol_cnt_r + 8'd1);
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_nxt_s = ST_FAULT;
                end
                default: begin
                    state_nxt_s = ST_RESET_PULSE;
                    timer_nxt_s = '0;
                end
            endcase
        end
    end

    // State, counters and outputs, all decoded from the next state so they register together.
    always_ff @(posedge osc_clk_i) begin
        if (rst_i) begin
            state_r       <= ST_RESET_PULSE;
            timer_r       <= '0;
            retry_cnt_r   <= 3'd0;
            lol_cnt_r     <= 8'd0;
            mmcm_rst_r    <= 1'b1;
            sys_reset_n_r <= 1'b0;
            clock_good_r  <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            timer_r       <= timer_nxt_s;
            retry_cnt_r   <= retry_nxt_s;
            lol_cnt_r     <= lol_nxt_s;
            mmcm_rst_r    <= (state_nxt_s == ST_RESET_PULSE) || (state_nxt_s == ST_FAULT);
            sys_reset_n_r <= (state_nxt_s == ST_RUN);
            clock_good_r  <= (state_nxt_s == ST_RUN);
            fault_r       <= (state_nxt_s == ST_FAULT);
        end
    end

    assign mmcm_rst_o    = mmcm_rst_r;
    assign sys_reset_n_o = sys_reset_n_r;
    assign clock_good_o  = clock_good_r;
    assign fault_o       = fault_r;
    assign retry_cnt_o   = retry_cnt_r;
    assign lol_cnt_o     = lol_cnt_r;
    assign state_o       = state_r;

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Scoreboard bench for mmcm_lock_supervisor: a rule-level reference model queues the
// expected outputs for every clock edge and an independent monitor compares them.
module tb_mmcm_lock_supervisor;

    localparam int P_RST    = 4;
    localparam int P_TO     = 32;
    localparam int P_STABLE = 8;
    localparam int P_MR     = 3;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       mmcm_locked_i;
    logic       force_reset_i;
    logic       mmcm_rst_o;
    logic       sys_reset_n_o;
    logic       clock_good_o;
    logic       fault_o;
    logic [2:0] retry_cnt_o;
    logic [7:0] lol_cnt_o;
    logic [2:0] state_o;

    typedef struct packed {
        logic [2:0] st;
        logic       mrst;
        logic       sysn;
        logic       cg;
        logic       flt;
        logic [2:0] retry;
        logic [7:0] lol;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: phase numbers follow the published state_o encoding.
    int   m_phase = 0;
    int   m_t     = 0;
    int   m_retry = 0;
    int   m_lol   = 0;
    bit   m_s1    = 1'b0;
    bit   m_s2    = 1'b0;

    initial forever #5 clk = ~clk;

    mmcm_lock_supervisor #(
        .RST_PULSE_CYCLES   (P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .STABLE_CYCLES      (P_STABLE),
        .MAX_RETRIES        (P_MR),
        .CNT_W              (16)
    ) dut (
        .osc_clk_i    (clk),
        .rst_i        (rst_i),
        .mmcm_locked_i(mmcm_locked_i),
        .force_reset_i(force_reset_i),
        .mmcm_rst_o   (mmcm_rst_o),
        .sys_reset_n_o(sys_reset_n_o),
        .clock_good_o (clock_good_o),
        .fault_o      (fault_o),
        .retry_cnt_o  (retry_cnt_o),
        .lol_cnt_o    (lol_cnt_o),
        .state_o      (state_o)
    );

    task automatic model_step(input bit r, input bit l, input bit f);
        bit   seen;
        exp_t e;
        if (r) begin
            m_phase = 0; m_t = 0; m_retry = 0; m_lol = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = l;
            if (f) begin
                m_phase = 0; m_t = 0; m_retry = 0;
            end else if (m_phase == 0) begin
                if (m_t == P_RST - 1) begin m_phase = 1; m_t = 0; end
                else m_t = m_t + 1;
            end else if (m_phase == 1) begin
                if (seen) begin
                    m_phase = 2; m_t = 0;
                end else if (m_t == P_TO - 1) begin
                    m_phase = (m_retry + 1 == P_MR) ? 4 : 0;
                    m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                    m_t = 0;
                end else begin
                    m_t = m_t + 1;
                end
            end else if (m_phase == 2) begin
                if (!seen) begin m_phase = 1; m_t = 0; end
                else if (m_t == P_STABLE - 1) begin m_phase = 3; m_retry = 0; m_t = 0; end
                else m_t = m_t + 1;
            end else if (m_phase == 3) begin
                if (!seen) begin
                    m_phase = 0; m_t = 0;
                    m_lol = (m_lol < 255) ? m_lol + 1 : 255;
                end
            end
        end
        e.st    = 3'(m_phase);
        e.mrst  = (m_phase == 0) || (m_phase == 4);
        e.sysn  = (m_phase == 3);
        e.cg    = (m_phase == 3);
        e.flt   = (m_phase == 4);
        e.retry = 3'(m_retry);
        e.lol   = 8'(m_lol);
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit r, input bit l, input bit f, input int n);
        repeat (n) begin
            rst_i         = r;
            mmcm_locked_i = l;
            force_reset_i = f;
            @(posedge clk);
            model_step(r, l, f);
            #1;
        end
    endtask

    // Monitor: every edge presents a full output set, checked against the queue head.
    initial forever begin
        @(negedge clk);
        cyc = cyc + 1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {state_o, mmcm_rst_o, sys_reset_n_o, clock_good_o, fault_o,
                     retry_cnt_o, lol_cnt_o};
            total = total + 1;
            if (mon_a !== mon_e) begin
                bad = bad + 1;
                $display("FAIL outputs cyc=%0d got st=%0d rst=%b sysn=%b cg=%b flt=%b retry=%0d lol=%0d want st=%0d rst=%b sysn=%b cg=%b flt=%b retry=%0d lol=%0d",
                         cyc, mon_a.st, mon_a.mrst, mon_a.sysn, mon_a.cg, mon_a.flt, mon_a.retry, mon_a.lol,
                         mon_e.st, mon_e.mrst, mon_e.sysn, mon_e.cg, mon_e.flt, mon_e.retry, mon_e.lol);
            end
        end
    end

    initial begin
        bit lv;
        bit fv;
        bit rv;
        rst_i = 1'b1; mmcm_locked_i = 1'b0; force_reset_i = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 3);
        // nominal bring-up, lock arriving 10 cycles into WAIT_LOCK
        tick(1'b0, 1'b0, 1'b0, P_RST + 10);
        tick(1'b0, 1'b1, 1'b0, 25);
        // one-cycle glitch while in STABLE
        tick(1'b0, 1'b0, 1'b1, 1);
        tick(1'b0, 1'b0, 1'b0, P_RST + $urandom_range(2, 8));
        tick(1'b0, 1'b1, 1'b0, $urandom_range(1, 7));
        tick(1'b0, 1'b0, 1'b0, 1);
        tick(1'b0, 1'b1, 1'b0, 25);
        // two losses of lock in RUN
        repeat (2) begin
            tick(1'b0, 1'b0, 1'b0, $urandom_range(1, 3));
            tick(1'b0, 1'b1, 1'b0, 30);
        end
        // force on the same edge the loss reaches the FSM
        tick(1'b0, 1'b0, 1'b0, 2);
        tick(1'b0, 1'b0, 1'b1, 1);
        tick(1'b0, 1'b1, 1'b0, 30);
        // lock never arrives, then late lock must be ignored in FAULT
        tick(1'b0, 1'b0, 1'b0, P_MR * (P_RST + P_TO) + 10);
        tick(1'b0, 1'b1, 1'b0, 20);
        // force out of FAULT
        tick(1'b0, 1'b1, 1'b1, 1);
        tick(1'b0, 1'b1, 1'b0, 25);
        // rst mid-STABLE, after losses have been counted
        tick(1'b0, 1'b0, 1'b1, 1);
        tick(1'b0, 1'b0, 1'b0, P_RST + 2);
        tick(1'b0, 1'b1, 1'b0, 2 + $urandom_range(1, 6));
        tick(1'b1, 1'b1, 1'b0, 1);
        tick(1'b0, 1'b1, 1'b0, 30);
        // rst mid-RUN with a nonzero loss count
        tick(1'b0, 1'b0, 1'b0, 1);
        tick(1'b0, 1'b1, 1'b0, 30);
        tick(1'b1, 1'b1, 1'b0, 1);
        tick(1'b0, 1'b1, 1'b0, 30);
        // randomized tail
        lv = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) lv = ~lv;
            fv = ($urandom_range(0, 63) == 0);
            rv = ($urandom_range(0, 199) == 0);
            tick(rv, lv, fv, 1);
        end
        tick(1'b0, 1'b1, 1'b0, 40);
        @(negedge clk);
        @(negedge clk);
        #1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
